// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default sizing for the serial pattern generator
// and the sequence-detector benches that consume its stream.
//   state_t       FSM state encoding (IDLE, SHIFT, GAP_WAIT, DONE)
//   SEQ_DATA_W    default maximum pattern length in bits
//   SEQ_REP_W     default width of the repeat count
//   SEQ_GAP       default idle bit-times between repetitions
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    GAP_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int SEQ_DATA_W = 8;
  localparam int SEQ_REP_W  = 4;
  localparam int SEQ_GAP    = 0;

endpackage

// File: rtl/seq_generator_if.sv
// seq_generator_if: request/stream bundle between a pattern source and the
// generator.
//   start       request to transmit (sampled only while the generator is idle)
//   pattern     bits to send, pattern[len] first, pattern[0] last
//   len         pattern length minus 1
//   repeat_cnt  repetitions minus 1
//   x           serial bit stream
//   x_valid     x carries a pattern bit this cycle
//   busy        transfer in progress
//   done        one-cycle pulse after the final bit
// Modports: master = requester / stream consumer, slave = generator.
interface seq_generator_if
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int REP_W  = SEQ_REP_W
) ();

  localparam int LEN_W = $clog2(DATA_W);

  logic              start;
  logic [DATA_W-1:0] pattern;
  logic [LEN_W-1:0]  len;
  logic [REP_W-1:0]  repeat_cnt;
  logic              x;
  logic              x_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, pattern, len, repeat_cnt,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_cnt,
    output x, x_valid, busy, done
  );

endinterface

// File: rtl/seq_bit_counter.sv
// seq_bit_counter: loadable down-counter with a zero flag.
//   clk       clock, rising edge
//   reset     asynchronous active-low clear
//   load      load load_val (takes priority over dec)
//   load_val  value to load
//   dec       decrement by one; holds at zero
//   count     current value
//   zero      count == 0
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/seq_generator.sv
// seq_generator: serialises a latched pattern MSB-first (from bit len down to
// bit 0), repeats it repeat_cnt+1 times with GAP idle cycles between passes,
// then pulses done for one cycle.
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    seq_generator_if.slave (start/pattern/len/repeat_cnt in,
//          x/x_valid/busy/done out)
// All outputs are registered; x/x_valid are computed from the transition
// being taken so the first bit appears the cycle after start is sampled.
module seq_generator
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int REP_W  = SEQ_REP_W,
  parameter int GAP    = SEQ_GAP
) (
  input  logic            clk,
  input  logic            reset,
  seq_generator_if.slave  bus
);

  localparam int LEN_W = $clog2(DATA_W);
  localparam int GAP_W = 4;
  localparam logic [LEN_W-1:0] LEN_ONE  = 1;
  // The gap counter runs GAP-1 down to 0, one cycle per count.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] pat_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              accept;

  logic x_reg, x_next;
  logic x_valid_reg, x_valid_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  // Bit index counter
  logic             bit_load, bit_dec, bit_zero;
  logic [LEN_W-1:0] bit_load_val, bit_cnt, bit_idx_m1;

  // Repetition counter
  logic             rep_load, rep_dec, rep_zero;
  logic [REP_W-1:0] rep_cnt;

  // Gap counter
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_cnt;

  // Only the zero flags of the repetition and gap counters steer the FSM.
  logic unused_cnt;
  assign unused_cnt = ^{rep_cnt, gap_cnt};

  assign bit_idx_m1 = bit_cnt - LEN_ONE;

  seq_bit_counter #(.W(LEN_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .load_val (bit_load_val),
    .dec      (bit_dec),
    .count    (bit_cnt),
    .zero     (bit_zero)
  );

  seq_bit_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (rep_load),
    .load_val (bus.repeat_cnt),
    .dec      (rep_dec),
    .count    (rep_cnt),
    .zero     (rep_zero)
  );

  seq_bit_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pat_reg     <= '0;
      len_reg     <= '0;
      x_reg       <= 1'b0;
      x_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      x_valid_reg <= x_valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      if (accept) begin
        pat_reg <= bus.pattern;
        len_reg <= bus.len;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    x_next       = 1'b0;
    x_valid_next = 1'b0;
    bit_load     = 1'b0;
    bit_load_val = len_reg;
    bit_dec      = 1'b0;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept       = 1'b1;
          state_next   = SHIFT;
          bit_load     = 1'b1;
          bit_load_val = bus.len;
          rep_load     = 1'b1;
          // First bit comes straight from the inputs being latched.
          x_next       = bus.pattern[bus.len];
          x_valid_next = 1'b1;
        end
      end

      SHIFT: begin
        if (!bit_zero) begin
          bit_dec      = 1'b1;
          x_next       = pat_reg[bit_idx_m1];
          x_valid_next = 1'b1;
        end else if (!rep_zero) begin
          // The repetition is consumed at the wrap point; whether a gap
          // follows is invisible to the count.
          rep_dec = 1'b1;
          if (GAP > 0) begin
            state_next = GAP_WAIT;
            gap_load   = 1'b1;
          end else begin
            bit_load     = 1'b1;
            x_next       = pat_reg[len_reg];
            x_valid_next = 1'b1;
          end
        end else begin
          state_next = DONE;
        end
      end

      GAP_WAIT: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          state_next   = SHIFT;
          bit_load     = 1'b1;
          x_next       = pat_reg[len_reg];
          x_valid_next = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == SHIFT) || (state_next == GAP_WAIT);
    done_next = (state_next == DONE);
  end

  assign bus.x       = x_reg;
  assign bus.x_valid = x_valid_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_seq_generator.sv
// tb_seq_generator: drives two generators (GAP=0 and GAP=2) with identical
// requests and compares every output, every cycle, against a stream model
// computed from the pattern/len/repeat/gap arithmetic.
module tb_seq_generator;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_generator_if #(.DATA_W(8), .REP_W(4)) bus0 ();
  seq_generator_if #(.DATA_W(8), .REP_W(4)) bus2 ();

  seq_generator #(.DATA_W(8), .REP_W(4), .GAP(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  seq_generator #(.DATA_W(8), .REP_W(4), .GAP(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs k cycles after the start sample of a single transfer.
  function automatic void model(input logic [7:0] p, input int l, input int r,
                                input int g, input int k,
                                output logic xv, output logic xb,
                                output logic bz, output logic dn);
    int total;
    int pos;
    total = (l + 1) * (r + 1) + g * r + 1;
    xv = 1'b0; xb = 1'b0; bz = 1'b0; dn = 1'b0;
    if (k >= 1 && k < total) begin
      bz  = 1'b1;
      pos = (k - 1) % (l + 1 + g);
      if (pos <= l) begin
        xv = 1'b1;
        xb = p[l - pos];
      end
    end else if (k == total) begin
      dn = 1'b1;
    end
  endfunction

  task automatic check_outs(input string tag, input logic xv0, input logic xb0,
                            input logic bz0, input logic dn0, input logic xv2,
                            input logic xb2, input logic bz2, input logic dn2);
    cmp({tag, " g0 x_valid"}, bus0.x_valid, xv0);
    cmp({tag, " g0 x"},       bus0.x,       xb0);
    cmp({tag, " g0 busy"},    bus0.busy,    bz0);
    cmp({tag, " g0 done"},    bus0.done,    dn0);
    cmp({tag, " g2 x_valid"}, bus2.x_valid, xv2);
    cmp({tag, " g2 x"},       bus2.x,       xb2);
    cmp({tag, " g2 busy"},    bus2.busy,    bz2);
    cmp({tag, " g2 done"},    bus2.done,    dn2);
  endtask

  task automatic check_cycle(input string tag, input int k, input logic [7:0] p,
                             input int l, input int r);
    logic xv0, xb0, bz0, dn0, xv2, xb2, bz2, dn2;
    model(p, l, r, 0, k, xv0, xb0, bz0, dn0);
    model(p, l, r, 2, k, xv2, xb2, bz2, dn2);
    check_outs($sformatf("%s k%0d", tag, k), xv0, xb0, bz0, dn0, xv2, xb2, bz2, dn2);
  endtask

  task automatic drive(input logic s, input logic [7:0] p, input logic [2:0] l,
                       input logic [3:0] r);
    bus0.start = s; bus0.pattern = p; bus0.len = l; bus0.repeat_cnt = r;
    bus2.start = s; bus2.pattern = p; bus2.len = l; bus2.repeat_cnt = r;
  endtask

  // One transfer; inputs are scrambled after acceptance. extra_k pulses start
  // again during that cycle (0 = never).
  task automatic run_xfer(input string tag, input logic [7:0] p, input int l,
                          input int r, input int extra_k);
    int t0;
    int t2;
    int last;
    t0   = (l + 1) * (r + 1) + 1;
    t2   = (l + 1) * (r + 1) + 2 * r + 1;
    last = ((t0 > t2) ? t0 : t2) + 2;
    @(negedge clk);
    drive(1'b1, p, 3'(l), 4'(r));
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      drive(k == extra_k, 8'($urandom), 3'($urandom), 4'($urandom));
      check_cycle(tag, k, p, l, r);
    end
    $display("xfer %s pattern=%h len=%0d rep=%0d cycles_g0=%0d cycles_g2=%0d",
             tag, p, l, r, t0, t2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rp;
    int rl;
    int rr;
    logic [7:0] hp;
    int m;

    // Reset state
    drive(1'b0, 8'h00, 3'd0, 4'd0);
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    // Start held during reset must not be seen before release.
    drive(1'b1, 8'hFF, 3'd7, 4'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 3'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    check_outs("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed streams
    run_xfer("basic_1011", 8'b0000_1011, 3, 0, 0);
    run_xfer("repeat_gap", 8'b0000_1011, 3, 1, 0);
    run_xfer("len0_rep2", 8'b0000_0001, 0, 2, 0);
    run_xfer("upper_bits_ignored", 8'b1111_0100, 3, 1, 0);
    run_xfer("full_width", 8'hA5, 7, 0, 0);
    run_xfer("restart_ignored", 8'b0000_1011, 3, 0, 2);

    // Reset during the third bit
    @(negedge clk);
    drive(1'b1, 8'b0000_1011, 3'd3, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(1'b0, 8'b0000_1011, 3'd3, 4'd0);
      check_cycle("abort", k, 8'b0000_1011, 3, 0);
    end
    #2 reset = 1'b0;
    #1 check_outs("abort_async", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_outs("abort_held", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_outs("abort_no_done", 0, 0, 0, 0, 0, 0, 0, 0);
    end
    run_xfer("after_abort", 8'b0000_1011, 3, 1, 0);

    // Start held high: back-to-back 2-bit transfers, 4-cycle period
    hp = 8'b0000_0010;
    @(negedge clk);
    drive(1'b1, hp, 3'd1, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) begin
        bus0.start = 1'b0;
        bus2.start = 1'b0;
      end
      m = (c - 1) % 4;
      check_outs($sformatf("held c%0d", c),
                 m < 2, (m < 2) ? hp[1 - m] : 1'b0, m < 2, m == 2,
                 m < 2, (m < 2) ? hp[1 - m] : 1'b0, m < 2, m == 2);
    end
    repeat (2) begin
      @(negedge clk);
      check_outs("held_release", 0, 0, 0, 0, 0, 0, 0, 0);
    end
    $display("xfer held_start pattern=%h len=1 rep=0 transfers=3", hp);

    // Randomized transfers
    for (int i = 0; i < 16; i++) begin
      rp = 8'($urandom);
      rl = int'($urandom_range(0, 7));
      rr = int'($urandom_range(0, 3));
      run_xfer($sformatf("rand%0d", i), rp, rl, rr, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter DATA_W, default 8, maximum pattern length in bits.
REQ-002 Parameter REP_W, default 4, width of the repeat count.
REQ-003 Parameter GAP, default 0, idle bit-times inserted between pattern repetitions (0..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserting 0 clears all state immediately.
REQ-006 start  input  1  request to transmit; sampled only in IDLE.
REQ-007 pattern  input  DATA_W  bits to send, MSB-aligned: pattern[len] goes first, pattern[0] goes last.
REQ-008 len  input  $clog2(DATA_W)  pattern length minus 1 (0 = one bit).
REQ-009 repeat_cnt  input  REP_W  repetitions minus 1 (0 = one pass).
REQ-010 x  output  1  serial bit stream; drives a sequence detector's x input directly.
REQ-011 x_valid  output  1  high on every cycle in which x carries a pattern bit.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  single-cycle pulse after the last bit of the last repetition.

Function
REQ-014 FSM states: IDLE, SHIFT, GAP_WAIT, DONE; state register encoded as a package enum.
REQ-015 IDLE + start=1 at a rising edge: latch pattern, len and repeat_cnt; bit index = len; repetition counter = repeat_cnt; go to SHIFT.
REQ-016 First bit appears on x, with x_valid=1, in the cycle immediately after start is sampled (latency 1 cycle).
REQ-017 SHIFT: output pattern_latched[index] for one cycle, then decrement index.
REQ-018 At index 0 with repetitions remaining: go to GAP_WAIT if GAP>0, otherwise reload index=len and stay in SHIFT with no bubble.
REQ-019 GAP_WAIT lasts exactly GAP cycles with x=0 and x_valid=0, then reload index=len, decrement the repetition counter and return to SHIFT.
REQ-020 At index 0 with the repetition counter at 0: go to DONE; done=1 for exactly one cycle; then go to IDLE.
REQ-021 Total cycles from start sample to done = (len+1)*(repeat_cnt+1) + GAP*repeat_cnt + 1.
REQ-022 x is 0 whenever x_valid=0; x and x_valid are registered outputs.
REQ-023 busy = 1 in SHIFT and GAP_WAIT, and 0 in IDLE and DONE.
REQ-024 start asserted while not in IDLE is ignored; it is neither queued nor restarting.
REQ-025 start held high through DONE begins a new transfer on the first IDLE cycle; in the back-to-back case there is one idle cycle between done and the next first bit.
REQ-026 pattern, len and repeat_cnt changes after acceptance do not affect the transfer in progress.
REQ-027 Bits of pattern above index len are ignored.

Reset
REQ-028 reset=0 forces state IDLE and x=0, x_valid=0, busy=0, done=0, and clears all counters and the latched pattern, asynchronously.
REQ-029 Reset asserted mid-transfer aborts the transfer with no done pulse; after release the block waits in IDLE for a new start.
REQ-030 The first start sampled is the one on the first rising edge with reset=1.

Structure
REQ-031 Package seq_pkg holds the state enum (IDLE, SHIFT, GAP_WAIT, DONE) and the default DATA_W, REP_W and GAP constants shared with the detector benches.
REQ-032 One sub-module, seq_bit_counter: a loadable down-counter with a zero flag, instantiated for the bit index, the repetition counter and the gap counter.

Verification
REQ-033 pattern=8'b0000_1011, len=3, repeat_cnt=0, GAP=0, start pulse -> x_valid high for 4 cycles with x=1,0,1,1; done pulses on cycle 5; a seq_detector driven from x raises z after the fourth bit.
REQ-034 Same pattern, repeat_cnt=1, GAP=2 -> x=1,0,1,1, then 2 cycles with x_valid=0, then 1,0,1,1; done pulses 11 cycles after the start sample.
REQ-035 len=0, pattern bit0=1, repeat_cnt=2 -> x=1 for 3 consecutive valid cycles; done on cycle 4.
REQ-036 start pulsed again on the second bit of a transfer -> that stream is unchanged, exactly one done pulse, and busy is never re-entered early.
REQ-037 reset driven low during the third bit -> x, x_valid and busy go to 0 immediately with no done pulse; after release, a new start produces a full correct stream.
REQ-038 start held high continuously with len=1 -> back-to-back transfers, each followed by a done pulse, with one idle cycle between done and the next first bit.
